// File: rtl/step_clk_gen_pkg.sv
// rtl/step_clk_gen_pkg.sv - shared encodings for the 74-series IC test tops
package step_clk_gen_pkg;

  localparam int BOARD_CLK_HZ = 27_000_000;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  // The button counts as down once a press is accepted, until a release is accepted.
  function automatic logic is_down(deb_state_t s);
    return (s == PRESSED) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/step_clk_gen_sync_2ff.sv
// rtl/step_clk_gen_sync_2ff.sv - generic two-flop synchronizer with a reset value
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/step_clk_gen.sv
// rtl/step_clk_gen.sv - debounced single-step / free-running clock source for IC models
module step_clk_gen
  import step_clk_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int RUN_HALF        = 13500000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic btn_n,
  input  logic run,
  output logic ic_clk,
  output logic step_pulse,
  output logic btn_level,
  output logic mode_q
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int RUN_W = $clog2(RUN_HALF);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_HALF - 1);

  logic btn_s;
  logic run_s;

  sync_2ff #(.RESET_VAL(1'b0)) u_btn_sync (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (~btn_n),
    .q   (btn_s)
  );

  sync_2ff #(.RESET_VAL(1'b0)) u_run_sync (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (run),
    .q   (run_s)
  );

  deb_state_t       state, state_next;
  logic [DEB_W-1:0] deb_cnt, deb_cnt_next;
  logic [RUN_W-1:0] run_cnt, run_cnt_next;
  logic             run_clk, run_clk_next;
  logic             level_next, mode_next, ic_next;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= RELEASED;
      deb_cnt    <= '0;
      run_cnt    <= '0;
      run_clk    <= 1'b0;
      ic_clk     <= 1'b0;
      step_pulse <= 1'b0;
      btn_level  <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      state      <= state_next;
      deb_cnt    <= deb_cnt_next;
      run_cnt    <= run_cnt_next;
      run_clk    <= run_clk_next;
      ic_clk     <= ic_next;
      step_pulse <= ic_next & ~ic_clk;
      btn_level  <= level_next;
      mode_q     <= mode_next;
    end
  end

  always_comb begin
    state_next   = state;
    deb_cnt_next = deb_cnt;
    case (state)
      RELEASED: begin
        if (btn_s) begin
          state_next   = PRESS_WAIT;
          deb_cnt_next = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_next = RELEASED;
        end else if (deb_cnt == DEB_LAST) begin
          state_next   = PRESSED;
          deb_cnt_next = '0;
        end else begin
          deb_cnt_next = deb_cnt + DEB_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_next   = RELEASE_WAIT;
          deb_cnt_next = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_next = PRESSED;
        end else if (deb_cnt == DEB_LAST) begin
          state_next   = RELEASED;
          deb_cnt_next = '0;
        end else begin
          deb_cnt_next = deb_cnt + DEB_W'(1);
        end
      end
      default: begin
        state_next   = RELEASED;
        deb_cnt_next = '0;
      end
    endcase

    level_next = is_down(state_next);

    // Mode only changes while the output is low, so a high phase is never cut short.
    mode_next = ic_clk ? mode_q : run_s;

    run_cnt_next = '0;
    run_clk_next = 1'b0;
    if (mode_next) begin
      if (run_cnt == RUN_LAST) begin
        run_cnt_next = '0;
        run_clk_next = ~run_clk;
      end else begin
        run_cnt_next = run_cnt + RUN_W'(1);
        run_clk_next = run_clk;
      end
    end

    ic_next = mode_next ? run_clk_next : level_next;
  end

endmodule

// File: tb/tb_step_clk_gen.sv
// tb/tb_step_clk_gen.sv - self-checking bench for step_clk_gen
module tb_step_clk_gen;

  localparam int DEB = 4;
  localparam int RH  = 3;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic btn_n;
  logic run;
  logic ic_clk, step_pulse, btn_level, mode_q;

  int checks = 0;
  int errors = 0;

  step_clk_gen #(.DEBOUNCE_CYCLES(DEB), .RUN_HALF(RH)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .btn_n      (btn_n),
    .run        (run),
    .ic_clk     (ic_clk),
    .step_pulse (step_pulse),
    .btn_level  (btn_level),
    .mode_q     (mode_q)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: inputs seen two edges late, a level flips after DEB+1
  // consecutive disagreeing samples, run clock derived from time spent in run mode.
  bit bq[$] = '{1'b0, 1'b0};
  bit rq[$] = '{1'b0, 1'b0};
  int m_cnt = 0;
  int m_t = 0;
  bit m_level = 0, m_mode = 0, m_ic = 0, m_pulse = 0;

  always @(posedge sys_clk or posedge sys_rst) begin : model
    bit bs, rs, mode_new, rclk, ic_new;
    if (sys_rst) begin
      bq = '{1'b0, 1'b0};
      rq = '{1'b0, 1'b0};
      m_cnt = 0; m_t = 0;
      m_level = 0; m_mode = 0; m_ic = 0; m_pulse = 0;
    end else begin
      bs = bq.pop_front(); bq.push_back(!btn_n);
      rs = rq.pop_front(); rq.push_back(run);
      if (bs != m_level) m_cnt++; else m_cnt = 0;
      if (m_cnt == DEB + 1) begin
        m_level = !m_level;
        m_cnt = 0;
      end
      mode_new = m_ic ? m_mode : rs;
      m_t = mode_new ? m_t + 1 : 0;
      rclk = ((m_t / RH) % 2) == 1;
      ic_new = mode_new ? rclk : m_level;
      m_pulse = ic_new && !m_ic;
      m_ic = ic_new;
      m_mode = mode_new;
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("model_ic_clk", ic_clk, m_ic);
    check("model_step_pulse", step_pulse, m_pulse);
    check("model_btn_level", btn_level, m_level);
    check("model_mode_q", mode_q, m_mode);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ic_clk"}, ic_clk, 1'b0);
    check({name, "_step_pulse"}, step_pulse, 1'b0);
    check({name, "_btn_level"}, btn_level, 1'b0);
    check({name, "_mode_q"}, mode_q, 1'b0);
  endtask

  typedef struct {
    logic btn_n;
    logic run;
    logic ic;
    logic pulse;
    logic level;
    logic mode;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int n, pulses, pulse_at, last_pulse, hi, bad;

    // Clean press held edges 1..10, released from edge 11.
    for (int i = 0; i < 18; i++) begin
      int e;
      e = i + 1;
      vecs[i].btn_n = (e <= 10) ? 1'b0 : 1'b1;
      vecs[i].run   = 1'b0;
      vecs[i].ic    = (e >= 7 && e <= 16);
      vecs[i].level = (e >= 7 && e <= 16);
      vecs[i].pulse = (e == 7);
      vecs[i].mode  = 1'b0;
    end

    sys_rst = 1'b1;
    btn_n = 1'b1;
    run = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (3) step();

    for (int i = 0; i < 18; i++) begin
      btn_n = vecs[i].btn_n;
      run   = vecs[i].run;
      step();
      check($sformatf("vec%0d_ic_clk", i), ic_clk, vecs[i].ic);
      check($sformatf("vec%0d_step_pulse", i), step_pulse, vecs[i].pulse);
      check($sformatf("vec%0d_btn_level", i), btn_level, vecs[i].level);
      check($sformatf("vec%0d_mode_q", i), mode_q, vecs[i].mode);
    end

    // Bounce 0,1,0,1 then steady 0: one pulse, six edges after the steady 0 begins.
    pulses = 0; pulse_at = -1;
    for (int i = 0; i < 16; i++) begin
      btn_n = (i < 4) ? logic'(i % 2) : 1'b0;
      step();
      if (step_pulse) begin
        pulses++;
        pulse_at = i;
      end
    end
    check_int("bounce_pulses", pulses, 1);
    check_int("bounce_pulse_at", pulse_at, 10);

    // Short release glitch while pressed.
    pulses = 0; bad = 0;
    for (int i = 0; i < 11; i++) begin
      btn_n = (i < 3) ? 1'b1 : 1'b0;
      step();
      if (step_pulse) pulses++;
      if (!btn_level || !ic_clk) bad++;
    end
    check_int("glitch_pulses", pulses, 0);
    check_int("glitch_level_drops", bad, 0);

    btn_n = 1'b1;
    repeat (12) step();
    check("released_level", btn_level, 1'b0);

    // Run mode: five periods of six cycles.
    run = 1'b1;
    n = 0;
    while (mode_q !== 1'b1 && n < 10) begin step(); n++; end
    check("run_mode_entered", mode_q, 1'b1);
    pulses = 0; last_pulse = -1; bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (step_pulse) begin
        if (last_pulse >= 0 && i - last_pulse != 2 * RH) bad++;
        last_pulse = i;
        pulses++;
      end
    end
    check_int("run_pulses", pulses, 5);
    check_int("run_period_errs", bad, 0);

    // Switch to step mode during a high phase.
    n = 0;
    while (step_pulse !== 1'b1 && n < 10) begin step(); n++; end
    check("switch_found_rise", step_pulse, 1'b1);
    run = 1'b0;
    hi = 1; n = 0;
    while (ic_clk === 1'b1 && n < 10) begin step(); if (ic_clk) hi++; n++; end
    check_int("switch_high_len", hi, RH);
    n = 0;
    while (mode_q !== 1'b0 && n < 3) begin step(); n++; end
    check("switch_mode_step", mode_q, 1'b0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin step(); if (ic_clk) bad++; end
    check_int("switch_stays_low", bad, 0);

    // Run requested while the button is held in step mode.
    btn_n = 1'b0;
    n = 0;
    while (btn_level !== 1'b1 && n < 12) begin step(); n++; end
    check("held_pressed", btn_level, 1'b1);
    run = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin step(); if (mode_q || !ic_clk) bad++; end
    check_int("held_waits", bad, 0);
    btn_n = 1'b1;
    n = 0;
    while (ic_clk !== 1'b0 && n < 12) begin step(); n++; end
    check("held_release_low", ic_clk, 1'b0);
    n = 0;
    while (mode_q !== 1'b1 && n < 3) begin step(); n++; end
    check("held_mode_run", mode_q, 1'b1);
    n = 0;
    while (step_pulse !== 1'b1 && n < 6) begin step(); n++; end
    check_int("held_first_rise", n, RH - 1);

    // Async reset during a run high phase.
    n = 0;
    while (ic_clk !== 1'b1 && n < 8) begin step(); n++; end
    check("rst_run_high", ic_clk, 1'b1);
    #2 sys_rst = 1'b1;
    #1 check_all_zero("rst_run");
    @(negedge sys_clk);
    sys_rst = 1'b0;
    run = 1'b0;

    // Async reset during PRESS_WAIT, then a full debounce is needed again.
    btn_n = 1'b0;
    repeat (4) step();
    #2 sys_rst = 1'b1;
    #1 check_all_zero("rst_pw");
    @(negedge sys_clk);
    sys_rst = 1'b0;
    pulses = 0; pulse_at = -1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (step_pulse) begin pulses++; pulse_at = i; end
    end
    check_int("rst_pw_pulses", pulses, 1);
    check_int("rst_pw_pulse_at", pulse_at, DEB + 2);

    // Async reset while pressed.
    #2 sys_rst = 1'b1;
    #1 check_all_zero("rst_pressed");
    @(negedge sys_clk);
    sys_rst = 1'b0;
    btn_n = 1'b1;
    repeat (3) step();

    // Random stimulus against the model.
    for (int seg = 0; seg < 300; seg++) begin
      int len;
      len = $urandom_range(1, 12);
      btn_n = logic'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) run = ~run;
      for (int k = 0; k < len; k++) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
